// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: pixel-rate divider plus H/V timing FSMs for a 640x480 VGA pipeline
//   clk, i_arst_n (async active-low reset), i_sclr (sync clear), i_en (run enable)
//   o_px_clk   one-clk strobe per pixel; all other outputs change with it
//   o_hsync/o_vsync sync pulses at level SYNC_POL; o_haddr_en/o_vaddr_en active regions
//   o_hidx/o_vidx pixel column/row, 0 outside the active region
//   VGA_FRAME_CNT_EN adds o_frame_start (pixel (0,0) strobe) and o_frame_cnt[15:0]
module vga_timing_ctrl #(
  parameter int   PX_DIV   = 4,
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       i_arst_n,
  input  logic       i_sclr,
  input  logic       i_en,
  output logic       o_px_clk,
  output logic       o_hsync,
  output logic       o_vsync,
  output logic       o_haddr_en,
  output logic       o_vaddr_en,
  output logic [9:0] o_hidx,
  output logic [8:0] o_vidx
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic        o_frame_start,
  output logic [15:0] o_frame_cnt
`endif
);
  localparam int DW = PX_DIV > 1 ? $clog2(PX_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(PX_DIV - 1);
  localparam logic [9:0] H_END = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] H_FP0 = 10'(H_ACTIVE);
  localparam logic [9:0] H_SY0 = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_BP0 = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_END = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] V_FP0 = 10'(V_ACTIVE);
  localparam logic [9:0] V_SY0 = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_BP0 = 10'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {S_ACT, S_FP, S_SYNC, S_BP} ph_e;

  function automatic ph_e nxt(ph_e s, logic [9:0] c, logic [9:0] fp0, logic [9:0] sy0, logic [9:0] bp0);
    return (s == S_ACT  && c == fp0)   ? S_FP   :
           (s == S_FP   && c == sy0)   ? S_SYNC :
           (s == S_SYNC && c == bp0)   ? S_BP   :
           (s == S_BP   && c == 10'd0) ? S_ACT  : s;
  endfunction

  logic [DW-1:0] cnt_d, cnt_q;
  logic [9:0]    hcnt_d, hcnt_q, vcnt_d, vcnt_q, hidx_d, hidx_q;
  logic [8:0]    vidx_d, vidx_q;
  ph_e           hst_d, hst_q, vst_d, vst_q;
  logic          tick, h_wrap, v_step;
  logic          px_clk_d, px_clk_q, hsync_d, hsync_q, vsync_d, vsync_q;
  logic          haddr_en_d, haddr_en_q, vaddr_en_d, vaddr_en_q;

  // Clear parks both counters on their last count (inside back porch), so the
  // first tick afterwards wraps straight onto pixel (0,0).
  always_comb begin
    tick       = i_en && !i_sclr && cnt_q == DIV_MAX;
    h_wrap     = hcnt_q == H_END;
    v_step     = tick && h_wrap;
    cnt_d      = i_sclr ? '0 : !i_en ? cnt_q : tick ? '0 : cnt_q + DW'(1);
    hcnt_d     = i_sclr ? H_END : !tick ? hcnt_q : h_wrap ? 10'd0 : hcnt_q + 10'd1;
    vcnt_d     = i_sclr ? V_END : !v_step ? vcnt_q : vcnt_q == V_END ? 10'd0 : vcnt_q + 10'd1;
    hst_d      = i_sclr ? S_BP : tick ? nxt(hst_q, hcnt_d, H_FP0, H_SY0, H_BP0) : hst_q;
    vst_d      = i_sclr ? S_BP : v_step ? nxt(vst_q, vcnt_d, V_FP0, V_SY0, V_BP0) : vst_q;
    px_clk_d   = tick;
    hsync_d    = hst_d == S_SYNC ? SYNC_POL : ~SYNC_POL;
    vsync_d    = vst_d == S_SYNC ? SYNC_POL : ~SYNC_POL;
    haddr_en_d = hst_d == S_ACT;
    vaddr_en_d = vst_d == S_ACT;
    hidx_d     = haddr_en_d ? hcnt_d : 10'd0;
    vidx_d     = vaddr_en_d ? vcnt_d[8:0] : 9'd0;
  end

  always_ff @(posedge clk or negedge i_arst_n)
    if (!i_arst_n) begin
      cnt_q      <= '0;
      hcnt_q     <= H_END;
      vcnt_q     <= V_END;
      hst_q      <= S_BP;
      vst_q      <= S_BP;
      px_clk_q   <= 1'b0;
      hsync_q    <= ~SYNC_POL;
      vsync_q    <= ~SYNC_POL;
      haddr_en_q <= 1'b0;
      vaddr_en_q <= 1'b0;
      hidx_q     <= '0;
      vidx_q     <= '0;
    end else begin
      cnt_q      <= cnt_d;
      hcnt_q     <= hcnt_d;
      vcnt_q     <= vcnt_d;
      hst_q      <= hst_d;
      vst_q      <= vst_d;
      px_clk_q   <= px_clk_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      haddr_en_q <= haddr_en_d;
      vaddr_en_q <= vaddr_en_d;
      hidx_q     <= hidx_d;
      vidx_q     <= vidx_d;
    end

  assign o_px_clk   = px_clk_q;
  assign o_hsync    = hsync_q;
  assign o_vsync    = vsync_q;
  assign o_haddr_en = haddr_en_q;
  assign o_vaddr_en = vaddr_en_q;
  assign o_hidx     = hidx_q;
  assign o_vidx     = vidx_q;

`ifdef VGA_FRAME_CNT_EN
  logic        frame_start_d, frame_start_q;
  logic [15:0] frame_cnt_d, frame_cnt_q;

  always_comb begin
    frame_start_d = tick && hcnt_d == 10'd0 && vcnt_d == 10'd0;
    frame_cnt_d   = i_sclr ? 16'd0 : frame_cnt_q + {15'd0, frame_start_d};
  end

  always_ff @(posedge clk or negedge i_arst_n)
    if (!i_arst_n) begin
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_d;
    end

  assign o_frame_start = frame_start_q;
  assign o_frame_cnt   = frame_cnt_q;
`endif
endmodule

// File: tb/tb_vga_timing_ctrl.sv
// tb_vga_timing_ctrl: three timing instances checked against a linear pixel-position model
module tb_vga_timing_ctrl;
  localparam int N = 3;
`ifdef VGA_FRAME_CNT_EN
  localparam int EW = 41;
`else
  localparam int EW = 24;
`endif
  localparam logic [EW-1:0] RA = EW'(24'h600000) << (EW - 24);
  localparam logic [3*EW-1:0] RST_V = {RA, {EW{1'b0}}, RA};

  int pd[N] = '{3, 1, 4};
  int ha[N] = '{8, 8, 640};
  int hf[N] = '{2, 2, 16};
  int hs[N] = '{3, 3, 96};
  int hb[N] = '{2, 2, 48};
  int va[N] = '{6, 6, 480};
  int vf[N] = '{1, 1, 10};
  int vs[N] = '{2, 2, 2};
  int vb[N] = '{1, 1, 33};
  bit sp[N] = '{0, 1, 0};

  logic clk = 0, arst_n = 0, sclr = 0, en = 0;
  logic px0, hs0, vs0, ha0, va0, px1, hs1, vs1, ha1, va1, px2, hs2, vs2, ha2, va2;
  logic [9:0] hi0, hi1, hi2;
  logic [8:0] vi0, vi1, vi2;
  logic [23:0] o0, o1, o2;
  logic [3*EW-1:0] obs;
  int ncmp = 0, nerr = 0;

  always #5 clk = ~clk;

`ifdef VGA_FRAME_CNT_EN
  logic fs0, fs1, fs2;
  logic [15:0] fc0, fc1, fc2;
  assign obs = {o0, fs0, fc0, o1, fs1, fc1, o2, fs2, fc2};
`else
  assign obs = {o0, o1, o2};
`endif
  assign o0 = {px0, hs0, vs0, ha0, va0, hi0, vi0};
  assign o1 = {px1, hs1, vs1, ha1, va1, hi1, vi1};
  assign o2 = {px2, hs2, vs2, ha2, va2, hi2, vi2};

  vga_timing_ctrl #(.PX_DIV(3), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b0)) u0 (
    .clk(clk), .i_arst_n(arst_n), .i_sclr(sclr), .i_en(en), .o_px_clk(px0),
    .o_hsync(hs0), .o_vsync(vs0), .o_haddr_en(ha0), .o_vaddr_en(va0), .o_hidx(hi0), .o_vidx(vi0)
`ifdef VGA_FRAME_CNT_EN
    , .o_frame_start(fs0), .o_frame_cnt(fc0)
`endif
  );
  vga_timing_ctrl #(.PX_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b1)) u1 (
    .clk(clk), .i_arst_n(arst_n), .i_sclr(sclr), .i_en(en), .o_px_clk(px1),
    .o_hsync(hs1), .o_vsync(vs1), .o_haddr_en(ha1), .o_vaddr_en(va1), .o_hidx(hi1), .o_vidx(vi1)
`ifdef VGA_FRAME_CNT_EN
    , .o_frame_start(fs1), .o_frame_cnt(fc1)
`endif
  );
  vga_timing_ctrl u2 (
    .clk(clk), .i_arst_n(arst_n), .i_sclr(sclr), .i_en(en), .o_px_clk(px2),
    .o_hsync(hs2), .o_vsync(vs2), .o_haddr_en(ha2), .o_vaddr_en(va2), .o_hidx(hi2), .o_vidx(vi2)
`ifdef VGA_FRAME_CNT_EN
    , .o_frame_start(fs2), .o_frame_cnt(fc2)
`endif
  );

  // Model: each instance is a divider phase plus a linear pixel number within the frame.
  int dv[N], pix[N], fc[N];
  bit mpx[N], mfs[N];

  function automatic int ht(int k);
    return ha[k] + hf[k] + hs[k] + hb[k];
  endfunction

  function automatic int vt(int k);
    return va[k] + vf[k] + vs[k] + vb[k];
  endfunction

  always @(posedge clk or negedge arst_n)
    for (int k = 0; k < N; k++) begin
      int np;
      bit t;
      if (!arst_n || sclr) begin
        dv[k] <= 0; pix[k] <= ht(k) * vt(k) - 1; mpx[k] <= 0; mfs[k] <= 0; fc[k] <= 0;
      end else if (en) begin
        t = dv[k] == pd[k] - 1;
        np = t ? (pix[k] + 1) % (ht(k) * vt(k)) : pix[k];
        dv[k] <= t ? 0 : dv[k] + 1;
        pix[k] <= np;
        mpx[k] <= t;
        mfs[k] <= t && np == 0;
        if (t && np == 0) fc[k] <= (fc[k] + 1) % 65536;
      end else begin
        mpx[k] <= 0; mfs[k] <= 0;
      end
    end

  function automatic logic [EW-1:0] expo(int k);
    int h, v;
    logic [23:0] b;
    h = pix[k] % ht(k);
    v = pix[k] / ht(k);
    b = {mpx[k],
         (h >= ha[k] + hf[k] && h < ha[k] + hf[k] + hs[k]) ? sp[k] : ~sp[k],
         (v >= va[k] + vf[k] && v < va[k] + vf[k] + vs[k]) ? sp[k] : ~sp[k],
         h < ha[k], v < va[k], 10'(h < ha[k] ? h : 0), 9'(v < va[k] ? v : 0)};
`ifdef VGA_FRAME_CNT_EN
    return {b, mfs[k], 16'(fc[k])};
`else
    return b;
`endif
  endfunction

  task automatic test_reset();
    int n;
    arst_n = 0; en = 1; sclr = 0;
    repeat (3) @(negedge clk);
    ncmp++; if (obs !== RST_V) begin nerr++; $display("FAIL reset_values got=%h exp=%h", obs, RST_V); end
    ncmp++; if (obs !== {expo(0), expo(1), expo(2)}) begin nerr++; $display("FAIL reset_model got=%h exp=%h", obs, {expo(0), expo(1), expo(2)}); end
    arst_n = 1;
    n = 0;
    for (int i = 1; i <= 8 && n == 0; i++) begin @(posedge clk); #1; if (px2) n = i; end
    ncmp++; if (n != 4) begin nerr++; $display("FAIL first_px_edge got=%0d exp=4", n); end
    ncmp++; if ({hi2, vi2, ha2, va2, hs2, vs2} !== {10'd0, 9'd0, 4'b1111}) begin
      nerr++; $display("FAIL first_pixel got=%h exp=%h", {hi2, vi2, ha2, va2, hs2, vs2}, {10'd0, 9'd0, 4'b1111});
    end
  endtask

  task automatic test_line();
    int n, nact, nlow, first, last, h639, h640;
    n = 0; nact = 0; nlow = 0; first = -1; last = -1; h639 = -1; h640 = -1;
    @(negedge clk); arst_n = 0; en = 1;
    @(negedge clk); arst_n = 1;
    for (int c = 0; c < 3400 && n < 800; c++) begin
      @(negedge clk);
      ncmp++; if (obs !== {expo(0), expo(1), expo(2)}) begin nerr++; $display("FAIL line_model got=%h exp=%h", obs, {expo(0), expo(1), expo(2)}); end
      if (px2) begin
        if (ha2) nact++;
        if (!hs2) begin nlow++; if (first < 0) first = n; last = n; end
        if (n == 639) h639 = int'(hi2);
        if (n == 640) h640 = int'(hi2);
        n++;
      end
    end
    ncmp++; if (n != 800) begin nerr++; $display("FAIL line_pulses got=%0d exp=800", n); end
    ncmp++; if (nact != 640) begin nerr++; $display("FAIL line_active got=%0d exp=640", nact); end
    ncmp++; if (nlow != 96 || first != 656 || last != 751) begin
      nerr++; $display("FAIL line_hsync got=%0d/%0d..%0d exp=96/656..751", nlow, first, last);
    end
    ncmp++; if (h639 != 639 || h640 != 0) begin nerr++; $display("FAIL line_hidx_end got=%0d,%0d exp=639,0", h639, h640); end
  endtask

  task automatic test_frame();
    int p0, v0, p1, v1, vmax, f0, f1;
    p0 = 0; v0 = 0; p1 = 0; v1 = 0; vmax = 0; f0 = 0; f1 = 0;
    en = 1;
    for (int c = 0; c < 450; c++) begin
      @(negedge clk);
      ncmp++; if (obs !== {expo(0), expo(1), expo(2)}) begin nerr++; $display("FAIL frame_model got=%h exp=%h", obs, {expo(0), expo(1), expo(2)}); end
      if (px0) begin p0++; if (!vs0) v0++; if (int'(vi0) > vmax) vmax = int'(vi0); end
      if (px1) begin p1++; if (vs1) v1++; end
`ifdef VGA_FRAME_CNT_EN
      if (fs0) f0++;
      if (fs1) f1++;
`else
      f0 = 1; f1 = 3;
`endif
    end
    ncmp++; if (p0 != 150 || v0 != 30 || vmax != 5) begin nerr++; $display("FAIL frame_div3 got=%0d/%0d/%0d exp=150/30/5", p0, v0, vmax); end
    ncmp++; if (p1 != 450 || v1 != 90) begin nerr++; $display("FAIL frame_div1 got=%0d/%0d exp=450/90", p1, v1); end
    ncmp++; if (f0 != 1 || f1 != 3) begin nerr++; $display("FAIL frame_starts got=%0d/%0d exp=1/3", f0, f1); end
  endtask

  task automatic test_pause();
    bit found;
    int n;
    logic [9:0] h;
    found = 0; n = 0; h = '0;
    en = 1;
    for (int c = 0; c < 3400 && !found; c++) begin
      @(negedge clk);
      if (px2 && hi2 == 10'd300) found = 1;
    end
    ncmp++; if (!found) begin nerr++; $display("FAIL pause_reach got=timeout exp=hidx300"); end
    en = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      ncmp++; if (px2 !== 1'b0 || hi2 !== 10'd300 || obs !== {expo(0), expo(1), expo(2)}) begin
        nerr++; $display("FAIL pause_hold got=%b/%0d exp=0/300", px2, hi2);
      end
    end
    en = 1;
    for (int i = 1; i <= 8 && n == 0; i++) begin @(posedge clk); #1; if (px2) begin n = i; h = hi2; end end
    ncmp++; if (n != 4 || h !== 10'd301) begin nerr++; $display("FAIL pause_resume got=%0d@%0d exp=301@4", h, n); end
  endtask

  task automatic test_sclr();
    bit found;
    int n;
    logic [18:0] idx;
    found = 0; n = 0; idx = '1;
    en = 1;
    for (int c = 0; c < 500 && !found; c++) begin
      @(negedge clk);
      if (px0 && va0 && vi0 == 9'd2 && hi0 == 10'd5) found = 1;
    end
    ncmp++; if (!found) begin nerr++; $display("FAIL sclr_reach got=timeout exp=row2col5"); end
    sclr = 1;
    @(negedge clk);
    ncmp++; if (obs !== RST_V) begin nerr++; $display("FAIL sclr_values got=%h exp=%h", obs, RST_V); end
    sclr = 0;
    for (int i = 1; i <= 8 && n == 0; i++) begin @(posedge clk); #1; if (px0) begin n = i; idx = {hi0, vi0}; end end
    ncmp++; if (n != 3 || idx !== 19'd0) begin nerr++; $display("FAIL sclr_restart got=%h@%0d exp=0@3", idx, n); end
    @(negedge clk);
    en = 0; sclr = 1;
    @(negedge clk);
    ncmp++; if (obs !== RST_V) begin nerr++; $display("FAIL sclr_over_en got=%h exp=%h", obs, RST_V); end
    ncmp++; if (obs !== {expo(0), expo(1), expo(2)}) begin nerr++; $display("FAIL sclr_model got=%h exp=%h", obs, {expo(0), expo(1), expo(2)}); end
    sclr = 0; en = 1;
  endtask

  task automatic test_arst();
    int n0, n2;
    n0 = 0; n2 = 0;
    en = 1;
    repeat (57) @(negedge clk);
    #2 arst_n = 0;
    #1;
    ncmp++; if (obs !== RST_V) begin nerr++; $display("FAIL arst_values got=%h exp=%h", obs, RST_V); end
    @(negedge clk);
    #2 arst_n = 1;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (px0 && n0 == 0) n0 = i;
      if (px2 && n2 == 0) n2 = i;
    end
    ncmp++; if (n0 != 3 || n2 != 4) begin nerr++; $display("FAIL arst_restart got=%0d/%0d exp=3/4", n0, n2); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      ncmp++; if (obs !== {expo(0), expo(1), expo(2)}) begin nerr++; $display("FAIL random_model got=%h exp=%h", obs, {expo(0), expo(1), expo(2)}); end
      en = $urandom_range(0, 9) != 0;
      sclr = $urandom_range(0, 299) == 0;
    end
    sclr = 0; en = 1;
  endtask

  initial begin
    test_reset();
    test_line();
    test_frame();
    test_pause();
    test_sclr();
    test_arst();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
